// File: rtl/lsb.sv
// In-order load/store buffer between the RS, the ROB and data memory.
// Entries issue to memory only after commit, with one access in flight.
module lsb #(
  parameter int ROB_WIDTH = 4,
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 from_rs,
  input  logic [ROB_WIDTH-1:0] from_rs_tag,
  input  logic                 from_rs_store,
  input  logic [1:0]           from_rs_width,
  input  logic                 from_rs_signed,
  input  logic [4:0]           from_rs_rd,
  input  logic [31:0]          from_rs_addr,
  input  logic [31:0]          from_rs_data,
  output logic                 to_rs_full,
  input  logic                 from_rob,
  input  logic [ROB_WIDTH-1:0] from_rob_tag,
  input  logic                 clear,
  output logic                 to_mem_req,
  output logic                 to_mem_we,
  output logic [31:0]          to_mem_addr,
  output logic [31:0]          to_mem_wdata,
  output logic [1:0]           to_mem_width,
  input  logic                 from_mem_done,
  input  logic [31:0]          from_mem_rdata,
  output logic                 to_reg_file,
  output logic [4:0]           to_reg_file_rd,
  output logic [31:0]          to_reg_file_wdata
);
  localparam int CW = LSB_WIDTH + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [LSB_WIDTH-1:0] head;
  logic [LSB_WIDTH-1:0] cptr;
  logic [LSB_WIDTH-1:0] tail;
  logic [CW-1:0]        count;

  logic [ROB_WIDTH-1:0] tag_q   [LSB_SIZE];
  logic                 st_q    [LSB_SIZE];
  logic [1:0]           width_q [LSB_SIZE];
  logic                 sg_q    [LSB_SIZE];
  logic [4:0]           rd_q    [LSB_SIZE];
  logic [31:0]          addr_q  [LSB_SIZE];
  logic [31:0]          data_q  [LSB_SIZE];

  logic                 enq;
  logic                 cmt;
  logic                 done;
  logic [LSB_WIDTH-1:0] head_nx;
  logic [LSB_WIDTH-1:0] cptr_nx;
  logic [LSB_WIDTH-1:0] tail_nx;
  logic [LSB_WIDTH-1:0] committed;
  logic [CW-1:0]        count_nx;
  logic [31:0]          ld_val;

  assign enq  = from_rs && !to_rs_full && !clear;
  assign cmt  = from_rob && (cptr != tail) &&
                (from_rob_tag == tag_q[cptr]);
  assign done = (state == WAIT) && from_mem_done;

  assign head_nx = done ? head + LSB_WIDTH'(1) : head;
  assign cptr_nx = cmt ? cptr + LSB_WIDTH'(1) : cptr;

  // A flush drops every uncommitted entry by pulling tail back.
  assign tail_nx = clear ? cptr_nx :
                   enq   ? tail + LSB_WIDTH'(1) : tail;

  assign committed = cptr_nx - head_nx;
  assign count_nx  = clear ? {1'b0, committed} :
                     count + CW'(enq) - CW'(done);

  always_comb begin
    ld_val = from_mem_rdata;
    unique case (width_q[head])
      2'b00: ld_val = sg_q[head] ?
        {{24{from_mem_rdata[7]}}, from_mem_rdata[7:0]} :
        {24'b0, from_mem_rdata[7:0]};
      2'b01: ld_val = sg_q[head] ?
        {{16{from_mem_rdata[15]}}, from_mem_rdata[15:0]} :
        {16'b0, from_mem_rdata[15:0]};
      default: ld_val = from_mem_rdata;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && enq) begin
      tag_q[tail]   <= from_rs_tag;
      st_q[tail]    <= from_rs_store;
      width_q[tail] <= from_rs_width;
      sg_q[tail]    <= from_rs_signed;
      rd_q[tail]    <= from_rs_rd;
      addr_q[tail]  <= from_rs_addr;
      data_q[tail]  <= from_rs_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      head              <= '0;
      cptr              <= '0;
      tail              <= '0;
      count             <= '0;
      to_rs_full        <= 1'b0;
      to_mem_req        <= 1'b0;
      to_mem_we         <= 1'b0;
      to_mem_addr       <= '0;
      to_mem_wdata      <= '0;
      to_mem_width      <= '0;
      to_reg_file       <= 1'b0;
      to_reg_file_rd    <= '0;
      to_reg_file_wdata <= '0;
    end else if (rdy_in) begin
      head        <= head_nx;
      cptr        <= cptr_nx;
      tail        <= tail_nx;
      count       <= count_nx;
      to_rs_full  <= count_nx >= CW'(LSB_SIZE - 1);
      to_mem_req  <= 1'b0;
      to_mem_we   <= 1'b0;
      to_reg_file <= 1'b0;
      unique case (state)
        IDLE: begin
          // cptr_nx lets a same-cycle commit issue on the next edge.
          if (head != cptr_nx) begin
            state        <= WAIT;
            to_mem_req   <= 1'b1;
            to_mem_we    <= st_q[head];
            to_mem_addr  <= addr_q[head];
            to_mem_wdata <= data_q[head];
            to_mem_width <= width_q[head];
          end
        end
        WAIT: begin
          if (from_mem_done) begin
            state <= IDLE;
            if (!st_q[head]) begin
              to_reg_file       <= rd_q[head] != 5'd0;
              to_reg_file_rd    <= rd_q[head];
              to_reg_file_wdata <= ld_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb.sv
// Bench for lsb: op-list reference model with scoreboard queues
// for memory requests and load writebacks.
module tb_lsb;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        from_rs;
  logic [3:0]  from_rs_tag;
  logic        from_rs_store;
  logic [1:0]  from_rs_width;
  logic        from_rs_signed;
  logic [4:0]  from_rs_rd;
  logic [31:0] from_rs_addr;
  logic [31:0] from_rs_data;
  logic        to_rs_full;
  logic        from_rob;
  logic [3:0]  from_rob_tag;
  logic        clear;
  logic        to_mem_req;
  logic        to_mem_we;
  logic [31:0] to_mem_addr;
  logic [31:0] to_mem_wdata;
  logic [1:0]  to_mem_width;
  logic        from_mem_done;
  logic [31:0] from_mem_rdata;
  logic        to_reg_file;
  logic [4:0]  to_reg_file_rd;
  logic [31:0] to_reg_file_wdata;

  lsb #(.ROB_WIDTH(4), .LSB_WIDTH(3), .LSB_SIZE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .from_rs(from_rs), .from_rs_tag(from_rs_tag),
    .from_rs_store(from_rs_store), .from_rs_width(from_rs_width),
    .from_rs_signed(from_rs_signed), .from_rs_rd(from_rs_rd),
    .from_rs_addr(from_rs_addr), .from_rs_data(from_rs_data),
    .to_rs_full(to_rs_full), .from_rob(from_rob),
    .from_rob_tag(from_rob_tag), .clear(clear),
    .to_mem_req(to_mem_req), .to_mem_we(to_mem_we),
    .to_mem_addr(to_mem_addr), .to_mem_wdata(to_mem_wdata),
    .to_mem_width(to_mem_width), .from_mem_done(from_mem_done),
    .from_mem_rdata(from_mem_rdata), .to_reg_file(to_reg_file),
    .to_reg_file_rd(to_reg_file_rd),
    .to_reg_file_wdata(to_reg_file_wdata)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  tag;
    logic        st;
    logic [1:0]  w;
    logic        sg;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] v;
  } wb_t;

  int errors = 0;
  int checks = 0;

  op_t  lsq[$];
  int   ncomm = 0;
  bit   model_full = 0;
  req_t exp_req[$];
  wb_t  exp_wb[$];

  bit          mem_pend = 0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          mem_lo = 0;
  int          mem_hi = 0;
  bit          fix_en = 0;
  logic [31:0] fix_val = '0;

  int          wb_cnt = 0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (fix_en) return fix_val;
    return a * 32'h9E3779B1 + 32'h7F4A7C15;
  endfunction

  function automatic logic [31:0] ext(input logic [1:0] w,
                                     input logic sg,
                                     input logic [31:0] d);
    longint v;
    if (w == 2'd0) begin
      v = d % 256;
      if (sg && v >= 128) v -= 256;
    end else if (w == 2'd1) begin
      v = d % 65536;
      if (sg && v >= 32768) v -= 65536;
    end else begin
      v = d;
    end
    return v[31:0];
  endfunction

  function automatic op_t mkop(input logic [3:0] tag, input logic st,
                               input logic [1:0] w, input logic sg,
                               input logic [4:0] rd,
                               input logic [31:0] a,
                               input logic [31:0] d);
    op_t o;
    o.tag = tag; o.st = st; o.w = w; o.sg = sg;
    o.rd = rd; o.addr = a; o.data = d;
    return o;
  endfunction

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (to_mem_req) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_mem_req", {to_mem_we, to_mem_addr}, '0);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("mem_req", {to_mem_we, to_mem_width, to_mem_addr,
                          to_mem_wdata}, r);
        end
      end
      if (to_reg_file) begin
        wb_cnt++;
        last_rd = to_reg_file_rd;
        last_wd = to_reg_file_wdata;
        if (exp_wb.size() == 0) begin
          chk("unexpected_wb", {to_reg_file_rd, to_reg_file_wdata}, '0);
        end else begin
          wb_t b;
          b = exp_wb.pop_front();
          chk("writeback", {to_reg_file_rd, to_reg_file_wdata}, b);
        end
      end
    end
  end

  // One clock: drive at negedge, update the model at posedge,
  // return at the following negedge.
  task automatic step(input bit enq, input op_t op, input bit cmt,
                      input logic [3:0] ctag, input bit clr);
    bit acc, cok, dn;
    from_rs = enq;
    from_rs_tag = op.tag;
    from_rs_store = op.st;
    from_rs_width = op.w;
    from_rs_signed = op.sg;
    from_rs_rd = op.rd;
    from_rs_addr = op.addr;
    from_rs_data = op.data;
    from_rob = cmt;
    from_rob_tag = ctag;
    clear = clr;
    dn = 0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        dn = 1;
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end
    from_mem_done = dn;
    from_mem_rdata = dn ? mem_val(mem_addr) : $urandom;
    acc = enq && !model_full && !clr;
    cok = cmt && ncomm < lsq.size() && ctag == lsq[ncomm].tag;
    @(posedge clk_in);
    if (cok) begin
      op_t c;
      req_t r;
      wb_t b;
      c = lsq[ncomm];
      r.we = c.st; r.w = c.w; r.addr = c.addr; r.wdata = c.data;
      exp_req.push_back(r);
      if (!c.st && c.rd != 0) begin
        b.rd = c.rd;
        b.v = ext(c.w, c.sg, mem_val(c.addr));
        exp_wb.push_back(b);
      end
      ncomm++;
    end
    if (dn) begin
      void'(lsq.pop_front());
      ncomm--;
    end
    if (acc) lsq.push_back(op);
    if (clr) while (lsq.size() > ncomm) void'(lsq.pop_back());
    model_full = lsq.size() >= 7;
    @(negedge clk_in);
    chk("rs_full", to_rs_full, model_full);
    if (to_mem_req) begin
      mem_pend = 1;
      mem_addr = to_mem_addr;
      mem_cnt = $urandom_range(mem_hi, mem_lo);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 4'd0, 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((lsq.size() != 0 || mem_pend) && n < budget) begin
      if (ncomm < lsq.size()) step(0, '0, 1, lsq[ncomm].tag, 0);
      else step(0, '0, 0, 4'd0, 0);
      n++;
    end
    chk("drain", {lsq.size() == 0, mem_pend}, {1'b1, 1'b0});
    idle(1);
  endtask

  initial begin
    int w0;
    rst_in = 1; rdy_in = 1;
    from_rs = 0; from_rs_tag = 0; from_rs_store = 0;
    from_rs_width = 0; from_rs_signed = 0; from_rs_rd = 0;
    from_rs_addr = 0; from_rs_data = 0; from_rob = 0;
    from_rob_tag = 0; clear = 0; from_mem_done = 0;
    from_mem_rdata = 0;
    #12;
    chk("rst_mem_req", to_mem_req, 0);
    chk("rst_mem_we", to_mem_we, 0);
    chk("rst_reg_file", to_reg_file, 0);
    chk("rst_full", to_rs_full, 0);
    chk("rst_addr", to_mem_addr, 0);
    chk("rst_wdata", to_mem_wdata, 0);
    chk("rst_width", to_mem_width, 0);
    chk("rst_rd", to_reg_file_rd, 0);
    chk("rst_reg_wdata", to_reg_file_wdata, 0);
    @(negedge clk_in);
    rst_in = 0;

    // store commit -> request on the next cycle
    step(1, mkop(4'd3, 1, 2'b10, 0, 5'd0, 32'h100, 32'hDEADBEEF),
         0, 4'd0, 0);
    chk("st_no_early_req", to_mem_req, 0);
    step(0, '0, 1, 4'd3, 0);
    chk("st_req", {to_mem_req, to_mem_we, to_mem_width},
        {1'b1, 1'b1, 2'b10});
    chk("st_addr", to_mem_addr, 32'h100);
    chk("st_wdata", to_mem_wdata, 32'hDEADBEEF);
    drain(20);

    // signed and unsigned byte loads of 0x80
    fix_en = 1; fix_val = 32'h0000_0080;
    step(1, mkop(4'd1, 0, 2'b00, 1, 5'd5, 32'h200, 0), 0, 4'd0, 0);
    drain(20);
    chk("ld_sb", {last_rd, last_wd}, {5'd5, 32'hFFFF_FF80});
    step(1, mkop(4'd2, 0, 2'b00, 0, 5'd5, 32'h204, 0), 0, 4'd0, 0);
    drain(20);
    chk("ld_ub", {last_rd, last_wd}, {5'd5, 32'h0000_0080});
    fix_en = 0;

    // mismatched commit tag, then rd=0 load
    step(1, mkop(4'd5, 0, 2'b10, 0, 5'd0, 32'h400, 0), 0, 4'd0, 0);
    step(0, '0, 1, 4'd4, 0);
    chk("bad_tag_no_req", to_mem_req, 0);
    idle(1);
    chk("bad_tag_no_req2", to_mem_req, 0);
    w0 = wb_cnt;
    drain(20);
    chk("rd0_no_wb", wb_cnt, w0);

    // fill to full, 8th enqueue dropped, then drain in order
    mem_lo = 0; mem_hi = 2;
    for (int i = 0; i < 8; i++) begin
      step(1, mkop(4'(i), 0, 2'($urandom_range(0, 2)), 1'($urandom),
                   5'(i + 10), $urandom, $urandom), 0, 4'd0, 0);
      if (i == 6) chk("full_at_7", to_rs_full, 1);
    end
    chk("full_after_8th", to_rs_full, 1);
    drain(60);
    chk("empty_not_full", to_rs_full, 0);

    // clear with first committed and in flight
    mem_lo = 3; mem_hi = 3;
    step(1, mkop(4'd7, 0, 2'b10, 0, 5'd9, 32'h500, 0), 0, 4'd0, 0);
    step(1, mkop(4'd8, 1, 2'b10, 0, 5'd0, 32'h504, 32'h55), 0, 4'd0, 0);
    step(0, '0, 1, 4'd7, 0);
    chk("clr_first_issued", to_mem_req, 1);
    step(0, '0, 0, 4'd0, 1);
    drain(20);
    chk("clr_first_done", last_rd, 5'd9);
    step(0, '0, 1, 4'd8, 0);
    chk("clr_second_gone", to_mem_req, 0);
    step(1, mkop(4'd9, 1, 2'b01, 0, 5'd0, 32'h508, 32'h77), 0, 4'd0, 0);
    step(0, '0, 1, 4'd9, 0);
    chk("clr_tail_eq_cptr", {to_mem_req, to_mem_addr}, {1'b1, 32'h508});
    drain(20);

    // randomized traffic
    mem_lo = 0; mem_hi = 3;
    for (int c = 0; c < 400; c++) begin
      bit e, k, cl;
      logic [3:0] t;
      op_t o;
      o = mkop(4'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
               1'($urandom), 5'($urandom_range(0, 31)),
               $urandom, $urandom);
      e = 1'($urandom);
      k = ($urandom % 3) != 0;
      cl = ($urandom % 40) == 0;
      if (ncomm < lsq.size()) begin
        t = lsq[ncomm].tag;
        if ($urandom % 5 == 0) t = t ^ 4'd1;
      end else begin
        t = 4'($urandom);
      end
      step(e, o, k, t, cl);
    end
    drain(300);

    // reset in the middle of an access
    mem_lo = 2; mem_hi = 2;
    step(1, mkop(4'd6, 0, 2'b10, 0, 5'd7, 32'h300, 0), 0, 4'd0, 0);
    step(0, '0, 1, 4'd6, 0);
    chk("r_mid_req", to_mem_req, 1);
    #2 rst_in = 1;
    #1;
    chk("r_mid_outs", {to_mem_req, to_mem_we, to_reg_file, to_rs_full},
        4'b0);
    chk("r_mid_data", {to_mem_addr, to_mem_width, to_reg_file_rd}, 0);
    exp_wb.delete(); exp_req.delete(); lsq.delete();
    ncomm = 0; model_full = 0; mem_pend = 0;
    @(negedge clk_in);
    rst_in = 0;
    from_rob = 0; from_rs = 0;
    from_mem_done = 1; from_mem_rdata = 32'h1234_5678;
    @(negedge clk_in);
    from_mem_done = 0;
    chk("r_late_no_wb", to_reg_file, 0);
    chk("r_late_no_req", to_mem_req, 0);
    @(negedge clk_in);
    chk("r_late_no_wb2", to_reg_file, 0);

    chk("end_req_q", exp_req.size(), 0);
    chk("end_wb_q", exp_wb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsb.md
LSB -- requirements
Module: lsb

Interface
REQ-001 Parameters: ROB_WIDTH, default 4, ROB tag width; LSB_WIDTH, default 3, queue index width; LSB_SIZE, default 8, queue depth (2^LSB_WIDTH).
REQ-002 clk_in  input  1  clock; the single clock for all state.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; when low, all state holds (reset still applies).
REQ-005 from_rs  input  1  enqueue valid; one memory op per cycle.
REQ-006 from_rs_tag  input  ROB_WIDTH  ROB tag of the op.
REQ-007 from_rs_store  input  1  1 = store, 0 = load.
REQ-008 from_rs_width  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 from_rs_signed  input  1  load sign-extend enable.
REQ-010 from_rs_rd  input  5  load destination register.
REQ-011 from_rs_addr / from_rs_data  input  32 each  effective address / store data.
REQ-012 to_rs_full  output  1  queue cannot accept an op next cycle.
REQ-013 from_rob / from_rob_tag  input  1 / ROB_WIDTH  commit pulse and committed tag.
REQ-014 clear  input  1  pipeline flush from the commit stage.
REQ-015 to_mem_req / to_mem_we  output  1 / 1  memory request strobe / write enable.
REQ-016 to_mem_addr / to_mem_wdata  output  32 / 32  request address / store data.
REQ-017 to_mem_width  output  2  access size, same encoding as from_rs_width.
REQ-018 from_mem_done / from_mem_rdata  input  1 / 32  completion pulse / read data, low-aligned.
REQ-019 to_reg_file / to_reg_file_rd / to_reg_file_wdata  output  1 / 5 / 32  load writeback.

Function
REQ-020 The queue SHALL be a circular FIFO with head, commit pointer cptr, and tail, all LSB_WIDTH bits wide, each wrapping modulo LSB_SIZE, plus a count register.
REQ-021 to_rs_full SHALL be registered and SHALL be 1 when count >= LSB_SIZE-1 after this cycle's updates.
REQ-022 When from_rs=1 and the queue is not full, the op SHALL be written at tail and tail SHALL advance by 1; an enqueue while full SHALL be dropped.
REQ-023 When from_rob=1 and from_rob_tag equals the tag stored at cptr (with cptr != tail), cptr SHALL advance by 1; a mismatch SHALL be ignored.
REQ-024 The FSM SHALL have two states, IDLE and WAIT.
REQ-025 IDLE -> WAIT: when head != cptr, a one-cycle to_mem_req SHALL be driven with the head entry's addr, data, width, and store bit.
REQ-026 WAIT -> IDLE: on from_mem_done; head SHALL advance by 1 and count SHALL decrement.
REQ-027 On a load completion, to_reg_file SHALL pulse 1 for one cycle with rd and the extended rdata, suppressed when rd=0.
REQ-028 Load extension: byte/half SHALL sign-extend bit 7/15 when signed, else zero-extend; word SHALL pass unchanged.
REQ-029 Uncommitted entries SHALL NOT be issued to memory.
REQ-030 Minimum latency from commit to to_mem_req SHALL be 1 cycle.
REQ-031 Enqueue, commit, and completion in the same cycle SHALL all take effect; count SHALL change by (+1 enqueue) - (1 completion).
REQ-032 On clear=1, tail SHALL be set to cptr and count SHALL be set to the committed count; committed entries and any in-flight WAIT access SHALL complete normally.
REQ-033 On clear=1, same-cycle from_rs SHALL be ignored.
REQ-034 to_mem_req and to_reg_file SHALL be single-cycle pulses, deasserted otherwise.

Reset
REQ-035 On rst_in=1 (asynchronous): head, cptr, tail, and count SHALL be 0; FSM SHALL be IDLE; to_mem_req, to_mem_we, to_reg_file, and to_rs_full SHALL be 0; addr, data, rd, and width outputs SHALL be 0.
REQ-036 Reset asserted in WAIT SHALL abandon the access; a later from_mem_done SHALL be ignored while IDLE.

Verification
REQ-037 Enqueue a store (tag 3, addr 0x100, data 0xDEADBEEF, word), then commit tag 3 -> next cycle to_mem_req=1, we=1, addr=0x100, wdata=0xDEADBEEF, width=10.
REQ-038 Load a byte, signed, rd=5; memory returns 0x00000080 -> to_reg_file=1, rd=5, wdata=0xFFFFFF80; the unsigned case -> 0x00000080.
REQ-039 Enqueue 7 ops without commit -> to_rs_full=1; an 8th enqueue is dropped; 20 enqueue/commit/complete cycles exercise index wrap with FIFO order preserved.
REQ-040 Two entries, the first committed and in WAIT, clear=1 -> the first completes, the second is never issued, and tail equals cptr.
REQ-041 Commit with a mismatched tag -> cptr unchanged and no to_mem_req; rd=0 load -> no to_reg_file pulse.
REQ-042 rst_in pulsed mid-WAIT -> all outputs 0 immediately, and a subsequent from_mem_done produces no writeback.
